// File: rtl/xpb_pkg.sv
// Shared constants and FSM state type for the xpb lookup-table generator.
package xpb_pkg;

    localparam int WORD_LEN    = 1024;
    localparam int DIGIT_BITS  = 5;
    localparam int NUM_ENTRIES = 1 << DIGIT_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } xpb_state_t;

endpackage

// File: rtl/xpb_mod_add.sv
// Combinational (a + b) mod m, exact when a < m and b < m.
module xpb_mod_add
    import xpb_pkg::*;
#(
    parameter int W = xpb_pkg::WORD_LEN
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] m,
    output logic [W-1:0] sum
);

    logic [W:0]   s;
    logic [W+1:0] d;

    assign s = {1'b0, a} + {1'b0, b};
    // The top bit of d is the sign of (s - m); a negative difference keeps s.
    assign d = {1'b0, s} - {2'b00, m};
    assign sum = d[W+1] ? W'(s) : W'(d);

endmodule

// File: rtl/xpb_table_gen.sv
// Streams the table j*C mod M for j = 0 .. 2^DIGIT_BITS-1 over a valid/ready port.
module xpb_table_gen
    import xpb_pkg::*;
#(
    parameter int WORD_LEN   = xpb_pkg::WORD_LEN,
    parameter int DIGIT_BITS = xpb_pkg::DIGIT_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WORD_LEN-1:0]   const_in,
    input  logic [WORD_LEN-1:0]   mod_in,
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIGIT_BITS-1:0] out_index,
    output logic [WORD_LEN-1:0]   out_data
);

    localparam logic [DIGIT_BITS-1:0] LAST_INDEX = {DIGIT_BITS{1'b1}};

    xpb_state_t            state_reg, state_next;
    logic [WORD_LEN-1:0]   c_reg, c_next;
    logic [WORD_LEN-1:0]   m_reg, m_next;
    logic [WORD_LEN-1:0]   data_reg, data_next;
    logic [DIGIT_BITS-1:0] index_reg, index_next;
    logic                  done_reg, done_next;
    logic [WORD_LEN-1:0]   sum_next;

    xpb_mod_add #(
        .W (WORD_LEN)
    ) u_mod_add (
        .a   (data_reg),
        .b   (c_reg),
        .m   (m_reg),
        .sum (sum_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            c_reg     <= '0;
            m_reg     <= '0;
            data_reg  <= '0;
            index_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            c_reg     <= c_next;
            m_reg     <= m_next;
            data_reg  <= data_next;
            index_reg <= index_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        c_next     = c_reg;
        m_next     = m_reg;
        data_next  = data_reg;
        index_next = index_reg;
        done_next  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    c_next     = const_in;
                    m_next     = mod_in;
                    data_next  = '0;
                    index_next = '0;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                // Without a handshake everything holds, so valid never drops early.
                if (out_ready) begin
                    if (index_reg == LAST_INDEX) begin
                        data_next  = '0;
                        index_next = '0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        data_next  = sum_next;
                        index_next = index_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state_reg == EMIT);
    assign out_valid = (state_reg == EMIT);
    assign done      = done_reg;
    assign out_index = index_reg;
    assign out_data  = data_reg;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Directed bench for xpb_table_gen: a small 8-bit/8-entry instance and a default-size instance.
module tb_xpb_table_gen;

    typedef logic [7:0][7:0] tbl8_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // 8-bit, 8-entry instance
    logic        start8 = 1'b0;
    logic [7:0]  const8 = '0;
    logic [7:0]  mod8 = '0;
    logic        busy8, done8, valid8;
    logic        ready8 = 1'b0;
    logic [2:0]  idx8;
    logic [7:0]  data8;

    // default-size instance
    logic          start1k = 1'b0;
    logic [1023:0] const1k = '0;
    logic [1023:0] mod1k = '0;
    logic          busy1k, done1k, valid1k;
    logic          ready1k = 1'b0;
    logic [4:0]    idx1k;
    logic [1023:0] data1k;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    xpb_table_gen #(
        .WORD_LEN   (8),
        .DIGIT_BITS (3)
    ) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start8),
        .const_in  (const8),
        .mod_in    (mod8),
        .busy      (busy8),
        .done      (done8),
        .out_valid (valid8),
        .out_ready (ready8),
        .out_index (idx8),
        .out_data  (data8)
    );

    xpb_table_gen dut1k (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1k),
        .const_in  (const1k),
        .mod_in    (mod1k),
        .busy      (busy1k),
        .done      (done1k),
        .out_valid (valid1k),
        .out_ready (ready1k),
        .out_index (idx1k),
        .out_data  (data1k)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    function automatic logic [1023:0] gold(input int j, input logic [1023:0] c, input logic [1023:0] m);
        logic [1029:0] p;
        logic [1029:0] r;
        p = 1030'(j) * {6'b0, c};
        r = p % {6'b0, m};
        return r[1023:0];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total_cnt++;
        if ({busy8, done8, valid8, idx8, data8} !== 14'd0) begin
            $display("FAIL reset8: got busy=%b done=%b valid=%b idx=%0d data=%0d required all 0",
                     busy8, done8, valid8, idx8, data8);
        end else pass_cnt++;
        total_cnt++;
        if ({busy1k, done1k, valid1k, idx1k} !== 8'd0 || data1k !== '0) begin
            $display("FAIL reset1k: got busy=%b done=%b valid=%b idx=%0d required all 0",
                     busy1k, done1k, valid1k, idx1k);
        end else pass_cnt++;
        rst_n = 1'b1;
        tick();
        tick();
        total_cnt++;
        if ({busy8, done8, valid8} !== 3'b000) begin
            $display("FAIL idle_after_reset: got busy=%b done=%b valid=%b required 000", busy8, done8, valid8);
        end else pass_cnt++;
        $display("reset: outputs checked");
    endtask

    // Runs one 8-entry table with M=251; bp selects the 1,0,0 repeating ready pattern.
    task automatic run8(input string name, input logic [7:0] c, input tbl8_t e, input bit bp);
        int j;
        int cyc;
        j = 0;
        cyc = 0;
        const8 = c;
        mod8 = 8'd251;
        ready8 = 1'b1;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        const8 = 8'd17;
        mod8 = 8'd13;
        while (j < 8 && cyc < 40) begin
            ready8 = bp ? (cyc % 3 == 0) : 1'b1;
            total_cnt++;
            if (valid8 !== 1'b1 || busy8 !== 1'b1 || idx8 !== j[2:0] || data8 !== e[j]) begin
                $display("FAIL %s beat: got valid=%b busy=%b idx=%0d data=%0d required valid=1 busy=1 idx=%0d data=%0d",
                         name, valid8, busy8, idx8, data8, j, e[j]);
            end else pass_cnt++;
            $display("%s: cyc=%0d idx=%0d data=%0d ready=%b", name, cyc, idx8, data8, ready8);
            if (ready8) j++;
            cyc++;
            tick();
        end
        ready8 = 1'b0;
        total_cnt++;
        if (j != 8) $display("FAIL %s timeout: got %0d beats required 8", name, j);
        else pass_cnt++;
        if (!bp) begin
            total_cnt++;
            if (cyc != 8) $display("FAIL %s latency: got done after %0d cycles required 9", name, cyc + 1);
            else pass_cnt++;
        end
        total_cnt++;
        if ({done8, busy8, valid8, idx8, data8} !== {3'b100, 3'd0, 8'd0}) begin
            $display("FAIL %s done: got done=%b busy=%b valid=%b idx=%0d data=%0d required done=1 others 0",
                     name, done8, busy8, valid8, idx8, data8);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if ({done8, busy8, valid8} !== 3'b000) begin
            $display("FAIL %s after_done: got done=%b busy=%b valid=%b required 000", name, done8, busy8, valid8);
        end else pass_cnt++;
    endtask

    task automatic test_basic();
        run8("basic_c100", 8'd100, {8'd198, 8'd98, 8'd249, 8'd149, 8'd49, 8'd200, 8'd100, 8'd0}, 1'b0);
    endtask

    task automatic test_max_const();
        run8("c_m_minus_1", 8'd250, {8'd244, 8'd245, 8'd246, 8'd247, 8'd248, 8'd249, 8'd250, 8'd0}, 1'b0);
    endtask

    task automatic test_zero_const();
        run8("c_zero", 8'd0, 64'd0, 1'b0);
    endtask

    task automatic test_backpressure();
        run8("backpressure", 8'd100, {8'd198, 8'd98, 8'd249, 8'd149, 8'd49, 8'd200, 8'd100, 8'd0}, 1'b1);
    endtask

    task automatic test_start_while_busy();
        tbl8_t e;
        e = {8'd198, 8'd98, 8'd249, 8'd149, 8'd49, 8'd200, 8'd100, 8'd0};
        const8 = 8'd100;
        mod8 = 8'd251;
        ready8 = 1'b1;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int j = 0; j < 8; j++) begin
            total_cnt++;
            if (valid8 !== 1'b1 || idx8 !== j[2:0] || data8 !== e[j]) begin
                $display("FAIL busy_start beat: got valid=%b idx=%0d data=%0d required valid=1 idx=%0d data=%0d",
                         valid8, idx8, data8, j, e[j]);
            end else pass_cnt++;
            start8 = (j == 3);
            const8 = (j == 3) ? 8'd7 : 8'd100;
            $display("busy_start: idx=%0d data=%0d start=%b", idx8, data8, start8);
            tick();
        end
        start8 = 1'b0;
        ready8 = 1'b0;
        total_cnt++;
        if ({done8, busy8} !== 2'b10) $display("FAIL busy_start done: got done=%b busy=%b required 1 0", done8, busy8);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (busy8 !== 1'b0) $display("FAIL busy_start idle: got busy=%b required 0", busy8);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        const8 = 8'd100;
        mod8 = 8'd251;
        ready8 = 1'b1;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("mid_index_before_reset", 64'(idx8), 64'd5);
        check("mid_data_before_reset", 64'(data8), 64'd249);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_valid_busy", 64'({valid8, busy8, done8}), 64'd0);
        check("async_reset_idx_data", 64'({idx8, data8}), 64'd0);
        #2 rst_n = 1'b1;
        tick();
        check("post_reset_no_done", 64'({done8, valid8, busy8}), 64'd0);
        $display("reset_mid: aborted at index 5");
        run8("after_reset", 8'd100, {8'd198, 8'd98, 8'd249, 8'd149, 8'd49, 8'd200, 8'd100, 8'd0}, 1'b0);
    endtask

    task automatic check1k(input string name, input int j, input logic [1023:0] c, input logic [1023:0] m);
        logic [1023:0] g;
        g = gold(j, c, m);
        total_cnt++;
        if (valid1k !== 1'b1 || idx1k !== j[4:0] || data1k !== g) begin
            $display("FAIL %s beat %0d: got valid=%b idx=%0d data[63:0]=%h required idx=%0d data[63:0]=%h",
                     name, j, valid1k, idx1k, data1k[63:0], j, g[63:0]);
        end else pass_cnt++;
        $display("%s: idx=%0d data[63:0]=%h", name, idx1k, data1k[63:0]);
    endtask

    task automatic test_wide_back_to_back();
        logic [1023:0] m;
        logic [1023:0] c1;
        logic [1023:0] c2;
        for (int w = 0; w < 32; w++) begin
            m[w*32 +: 32]  = $urandom;
            c1[w*32 +: 32] = $urandom;
            c2[w*32 +: 32] = $urandom;
        end
        m[1023] = 1'b1;
        m[0] = 1'b1;
        c1[1023] = 1'b0;
        c2[1023] = 1'b0;
        mod1k = m;
        const1k = c1;
        ready1k = 1'b1;
        start1k = 1'b1;
        tick();
        start1k = 1'b0;
        for (int j = 0; j < 32; j++) begin
            check1k("wide_t1", j, c1, m);
            tick();
        end
        check("wide_t1_done", 64'({done1k, valid1k, busy1k}), 64'b100);
        const1k = c2;
        start1k = 1'b1;
        tick();
        start1k = 1'b0;
        const1k = '0;
        for (int j = 0; j < 32; j++) begin
            check1k("wide_t2", j, c2, m);
            tick();
        end
        check("wide_t2_done", 64'({done1k, valid1k, busy1k}), 64'b100);
        ready1k = 1'b0;
        tick();
        check("wide_t2_idle", 64'({done1k, valid1k, busy1k}), 64'b000);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_const();
        test_zero_const();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid();
        test_wide_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
